vga_sync_generator: RTL



---
 rtl/vga_sync_generator_if.sv | 37 +++
 rtl/vga_sync_generator.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator_if.sv
// vga_sync_generator_if: timing bundle from the VGA sync generator.
//   current_row  - horizontal pixel counter (x)
//   current_line - vertical line counter (y)
//   enable       - visible-area flag
//   hsync/vsync  - active-low sync pulses for the VGA connector
//   pixel_tick   - one-clock pulse per pixel period
//   frame_start  - one-clock pulse when the counters wrap to (0,0)
// Modports: master (the generator drives), slave (renderer / connector side).
interface vga_sync_generator_if;
  logic [9:0] current_row;
  logic [9:0] current_line;
  logic       enable;
  logic       hsync;
  logic       vsync;
  logic       pixel_tick;
  logic       frame_start;

  modport master (
    output current_row,
    output current_line,
    output enable,
    output hsync,
    output vsync,
    output pixel_tick,
    output frame_start
  );

  modport slave (
    input current_row,
    input current_line,
    input enable,
    input hsync,
    input vsync,
    input pixel_tick,
    input frame_start
  );
endinterface

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: 640x480@60 Hz VGA timing (defaults).
// A clock divider produces a pixel tick every CLK_DIV system clocks; on each tick the
// horizontal counter advances, wrapping into the vertical counter. All outputs are
// registered from the counter values and therefore lag the internal counters by one clock.
// Ports:
//   clk_in - system clock
//   reset  - asynchronous, active-high reset
//   vga    - vga_sync_generator_if.master (row/line, enable, hsync, vsync, pixel_tick,
//            frame_start)
// Optional feature: define VGA_SYNC_DELAY_EN to pass hsync, vsync and frame_start through
// one extra register stage so they line up with the renderer's registered colour.
module vga_sync_generator #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 4
) (
  input logic                  clk_in,
  input logic                  reset,
  vga_sync_generator_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Internal counters
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;

  assign tick   = (div_cnt_q == DIV_LAST);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  // Output decode from the current counter values
  logic enable_d, hsync_d, vsync_d, frame_start_d;

  always_comb begin
    enable_d      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync_d       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vsync_d       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    frame_start_d = tick && h_wrap && v_wrap;
  end

  // Output registers: one clock behind the counters
  logic [9:0] row_q, line_q;
  logic       enable_q, hsync_q, vsync_q, pixel_tick_q, frame_start_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      row_q         <= '0;
      line_q        <= '0;
      enable_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      row_q         <= h_cnt_q;
      line_q        <= v_cnt_q;
      enable_q      <= enable_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pixel_tick_q  <= tick;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.current_row  = row_q;
  assign vga.current_line = line_q;
  assign vga.enable       = enable_q;
  assign vga.pixel_tick   = pixel_tick_q;

`ifdef VGA_SYNC_DELAY_EN
  // Extra stage so sync lines up with the renderer's registered colour
  logic hsync_dly_q, vsync_dly_q, frame_start_dly_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hsync_dly_q       <= 1'b1;
      vsync_dly_q       <= 1'b1;
      frame_start_dly_q <= 1'b0;
    end else begin
      hsync_dly_q       <= hsync_q;
      vsync_dly_q       <= vsync_q;
      frame_start_dly_q <= frame_start_q;
    end
  end

  assign vga.hsync       = hsync_dly_q;
  assign vga.vsync       = vsync_dly_q;
  assign vga.frame_start = frame_start_dly_q;
`else
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;
`endif

endmodule
